spike_train_encoder: RTL and testbench

Rate-coding spike source that produces the M-bit `input_spikes` vector consumed by the LIF neuron datapath. Per-channel 2-bit rates are captured at frame start. Each timestep `tick` advances a per-channel phase accumulator; a channel fires on accumulator carry-out. It emits one registered spike vector per timestep for a fixed-length frame. `spikes_valid` drives the neuron's `enable`, and the neuron's `input_spikes` is taken from `spikes_out`.

---
 rtl/spike_train_encoder.sv | 101 ++++++++++
 tb/tb_spike_train_encoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spike_train_encoder.sv
// Rate-coded spike source: each channel adds its captured 2-bit rate into a
// 2-bit phase accumulator on every timestep and fires on the carry-out.
module spike_train_encoder #(
  parameter int unsigned M         = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CW        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2*M-1:0]   rates,
  input  logic             tick,
  output logic [M-1:0]     spikes_out,
  output logic             spikes_valid,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    timestep
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [2*M-1:0]   rate_q;
  logic [2*M-1:0]   acc_q;
  logic [2*M-1:0]   acc_next;
  logic [M-1:0]     fire;
  logic             accept_start;
  logic             step;
  logic             last_step;

  always_comb begin
    accept_start = (state != RUN) && start;
    step         = (state == RUN) && tick;
    last_step    = step && (timestep == CW'(FRAME_LEN - 1));
  end

  always_comb begin
    logic [2:0] sum;
    sum      = '0;
    fire     = '0;
    acc_next = '0;
    for (int unsigned i = 0; i < M; i++) begin
      sum                  = {1'b0, acc_q[2*i +: 2]} + {1'b0, rate_q[2*i +: 2]};
      fire[i]              = sum[2];
      acc_next[2*i +: 2]   = sum[1:0];
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) state_next = RUN;
        RUN:        if (last_step) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Abort outranks start, and an accepted start swallows a same-cycle tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_q       <= '0;
      acc_q        <= '0;
      spikes_out   <= '0;
      spikes_valid <= 1'b0;
      done         <= 1'b0;
      timestep     <= '0;
    end else begin
      spikes_out   <= '0;
      spikes_valid <= 1'b0;
      done         <= 1'b0;
      if (abort) begin
        rate_q   <= '0;
        acc_q    <= '0;
        timestep <= '0;
      end else if (accept_start) begin
        rate_q   <= rates;
        acc_q    <= '0;
        timestep <= '0;
      end else if (step) begin
        acc_q        <= acc_next;
        spikes_out   <= fire;
        spikes_valid <= 1'b1;
        done         <= last_step;
        timestep     <= timestep + CW'(1);
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_spike_train_encoder.sv
// Scoreboard bench for spike_train_encoder: a frame-level reference model
// predicts each spike vector from t*rate/4 carry counting.
module tb_spike_train_encoder;

  localparam int unsigned M         = 8;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned CW        = 8;

  typedef struct {
    logic [M-1:0]  spk;
    logic          dn;
    logic [CW-1:0] ts;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [2*M-1:0]   rates = '0;
  logic             tick = 1'b0;
  logic [M-1:0]     spikes_out;
  logic             spikes_valid;
  logic             busy;
  logic             done;
  logic [CW-1:0]    timestep;

  spike_train_encoder #(.M(M), .FRAME_LEN(FRAME_LEN), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .rates(rates),
    .tick(tick), .spikes_out(spikes_out), .spikes_valid(spikes_valid),
    .busy(busy), .done(done), .timestep(timestep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Model: 0 idle, 1 running, 2 frame complete.
  int m_mode = 0;
  int m_ts = 0;
  logic [2*M-1:0] m_rates = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] predict(input logic [2*M-1:0] r, input int t);
    logic [M-1:0] v;
    int rate;
    v = '0;
    for (int i = 0; i < int'(M); i++) begin
      rate = int'(r[2*i +: 2]);
      v[i] = ((t * rate) / 4) != (((t - 1) * rate) / 4);
    end
    return v;
  endfunction

  task automatic drive(input logic s, input logic t, input logic a, input logic [2*M-1:0] r);
    exp_t e;
    start = s; tick = t; abort = a; rates = r;
    @(posedge clk);
    if (a) begin
      m_mode = 0; m_ts = 0; m_rates = '0;
    end else if (m_mode != 1 && s) begin
      m_mode = 1; m_ts = 0; m_rates = r;
    end else if (m_mode == 1 && t) begin
      m_ts++;
      e.spk = predict(m_rates, m_ts);
      e.dn  = (m_ts == int'(FRAME_LEN));
      e.ts  = CW'(m_ts);
      exp_q.push_back(e);
      if (e.dn) m_mode = 2;
    end
    #1;
    start = 1'b0; tick = 1'b0; abort = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (spikes_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(spikes_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("spikes_out", 32'(spikes_out), 32'(e.spk));
          chk("done_with_valid", 32'(done), 32'(e.dn));
          chk("timestep_on_valid", 32'(timestep), 32'(e.ts));
        end
      end else begin
        chk("spikes_idle_zero", 32'(spikes_out), 32'd0);
        chk("done_without_valid", 32'(done), 32'd0);
      end
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("timestep", 32'(timestep), 32'(m_ts));
    end
  end

  initial begin : stim
    logic [2*M-1:0] ra;
    logic [2*M-1:0] rb;
    #12;
    chk("reset_spikes", 32'(spikes_out), 32'd0);
    chk("reset_valid", 32'(spikes_valid), 32'd0);
    chk("reset_busy_done", 32'({busy, done}), 32'd0);
    chk("reset_timestep", 32'(timestep), 32'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Reset mid-frame after 3 ticks with all rates 1.
    drive(1'b1, 1'b0, 1'b0, 16'h5555);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk); #1;
    reset = 1'b0;
    m_mode = 0; m_ts = 0; m_rates = '0;
    #1;
    chk("async_reset_outputs", 32'({spikes_out, spikes_valid, busy, done}), 32'd0);
    chk("async_reset_timestep", 32'(timestep), 32'd0);
    #4 reset = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, '0);
    idle_cycles(2);

    // Rate patterns {3,2,1,0} with back-to-back ticks through a full frame.
    drive(1'b1, 1'b0, 1'b0, 16'hE4E4);
    for (int k = 0; k < int'(FRAME_LEN); k++) drive(1'b0, 1'b1, 1'b0, $urandom);
    idle_cycles(2);
    chk("frame_end_timestep", 32'(timestep), 32'(FRAME_LEN));

    // Sparse ticks, 5 cycles apart.
    drive(1'b1, 1'b0, 1'b0, $urandom);
    for (int k = 0; k < int'(FRAME_LEN); k++) begin
      drive(1'b0, 1'b1, 1'b0, $urandom);
      idle_cycles(4);
    end

    // Start/tick collision, then start with new rates during RUN.
    ra = $urandom; rb = ~ra;
    drive(1'b1, 1'b1, 1'b0, ra);
    drive(1'b1, 1'b1, 1'b0, rb);
    for (int k = 0; k < int'(FRAME_LEN) - 1; k++) drive(1'b0, 1'b1, 1'b0, rb);
    idle_cycles(1);

    // Abort on the third tick; abort together with start.
    drive(1'b1, 1'b0, 1'b0, 16'hFFFF);
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, '0);
    idle_cycles(1);
    drive(1'b1, 1'b0, 1'b1, 16'hFFFF);
    idle_cycles(1);

    // Restart after DONE with ticks while DONE.
    drive(1'b1, 1'b0, 1'b0, 16'hE4E4);
    for (int k = 0; k < int'(FRAME_LEN); k++) drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 16'hB1B1);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, '0);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      drive(($urandom % 8) == 0, ($urandom % 2) == 0, ($urandom % 30) == 0, $urandom);

    idle_cycles(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
